// File: rtl/i2s_sample_tx_pkg.sv
// Shared constants and state type for the left-justified I2S sample transmitter.
package i2s_sample_tx_pkg;

    localparam int FRAME_SLOTS = 32;
    localparam int SAMPLE_BITS = 16;
    localparam int SLOT_W      = $clog2(FRAME_SLOTS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Both channel groups send the word MSB first, so the bit index is 15 - (slot mod 16).
    function automatic logic [3:0] slot_bit_index(input logic [3:0] slot_lo);
        return ~slot_lo;
    endfunction

endpackage

// File: rtl/i2s_bit_timer.sv
// Bit-clock divider and frame slot counter; counters rest at zero while disabled.
module i2s_bit_timer
    import i2s_sample_tx_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    output logic              o_half_tick,
    output logic              o_slot_start,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_frame_last
);

    logic [7:0]        r_div;
    logic              r_half;
    logic [SLOT_W-1:0] r_slot;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div  <= '0;
            r_half <= 1'b0;
            r_slot <= '0;
        end else if (!i_en) begin
            r_div  <= '0;
            r_half <= 1'b0;
            r_slot <= '0;
        end else if (o_half_tick) begin
            r_div  <= '0;
            r_half <= ~r_half;
            if (r_half) begin
                r_slot <= r_slot + 1'b1;
            end
        end else begin
            r_div <= r_div + 8'd1;
        end
    end

    // Strobes describe the current cycle: the next cycle starts a new half-period / slot.
    assign o_half_tick  = (r_div == 8'(CLK_DIV - 1));
    assign o_slot_start = o_half_tick & r_half;
    assign o_slot       = r_slot;
    assign o_frame_last = o_slot_start & (r_slot == SLOT_W'(FRAME_SLOTS - 1));

endmodule

// File: rtl/i2s_sample_tx.sv
// Serialises one mono sample per frame onto both channels of a left-justified link
// and issues the new_frame pacing pulse to the upstream player.
module i2s_sample_tx
    import i2s_sample_tx_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int SAMPLE_BITS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [SAMPLE_BITS-1:0] sample,
    output logic                   new_frame,
    output logic                   bclk,
    output logic                   lrclk,
    output logic                   sdata,
    output logic                   busy
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_start;
    logic                   w_capture;
    logic                   w_timer_en;
    logic                   w_half_tick;
    logic                   w_slot_start;
    logic                   w_frame_last;
    logic [SLOT_W-1:0]      w_slot;
    logic [SLOT_W-1:0]      w_slot_nxt;
    logic [3:0]             w_bit_idx;
    logic [SAMPLE_BITS-1:0] r_hold;
    logic [SAMPLE_BITS-1:0] w_hold_nxt;
    logic                   r_bclk;
    logic                   r_lrclk;
    logic                   r_sdata;
    logic                   r_new_frame;
    logic                   r_busy;

    assign w_timer_en = (r_state != IDLE);

    i2s_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk          (clk),
        .i_rst_n      (reset),
        .i_en         (w_timer_en),
        .o_half_tick  (w_half_tick),
        .o_slot_start (w_slot_start),
        .o_slot       (w_slot),
        .o_frame_last (w_frame_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_nxt = RUN;
                    w_start     = 1'b1;
                    w_capture   = 1'b1;
                end
            end
            RUN: begin
                if (w_frame_last) begin
                    w_capture = 1'b1;
                    if (!enable) begin
                        w_state_nxt = IDLE;
                    end
                end else if (!enable) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_frame_last) begin
                    if (enable) begin
                        w_capture   = 1'b1;
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (enable) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so they are computed from the position the timer moves to next.
    assign w_hold_nxt = w_capture ? sample : r_hold;
    assign w_slot_nxt = w_slot_start ? w_slot + 1'b1 : w_slot;
    assign w_bit_idx  = slot_bit_index(w_slot_nxt[3:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold <= '0;
        end else if (w_capture) begin
            r_hold <= sample;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bclk      <= 1'b0;
            r_lrclk     <= 1'b0;
            r_sdata     <= 1'b0;
            r_new_frame <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_state_nxt == IDLE) begin
            r_bclk      <= 1'b0;
            r_lrclk     <= 1'b0;
            r_sdata     <= 1'b0;
            r_new_frame <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_start || w_slot_start) begin
            r_bclk      <= 1'b0;
            r_lrclk     <= ~w_slot_nxt[SLOT_W-1];
            r_sdata     <= w_hold_nxt[w_bit_idx];
            r_new_frame <= (w_slot_nxt == '0);
            r_busy      <= 1'b1;
        end else begin
            r_new_frame <= 1'b0;
            r_busy      <= 1'b1;
            if (w_half_tick) begin
                r_bclk <= 1'b1;
            end
        end
    end

    assign new_frame = r_new_frame;
    assign bclk      = r_bclk;
    assign lrclk     = r_lrclk;
    assign sdata     = r_sdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Directed bench for i2s_sample_tx: frame scoreboard on the CLK_DIV=2 instance,
// pacing on CLK_DIV=4 and bit-clock phase checks on CLK_DIV=3.
module tb_i2s_sample_tx;

    logic        clk;
    logic        rst_n;
    logic        en2, en3, en4;
    logic [15:0] smp;
    logic        nf2, bclk2, lr2, sd2, busy2;
    logic        nf3, bclk3, lr3, sd3, busy3;
    logic        nf4, bclk4, lr4, sd4, busy4;

    int          checks = 0;
    int          failures = 0;
    int          nf_count2 = 0;
    int          frames_done = 0;
    int          runs3 = 0;
    logic [15:0] exp_q[$];

    i2s_sample_tx #(.CLK_DIV(2), .SAMPLE_BITS(16)) u_dut2 (
        .clk(clk), .reset(rst_n), .enable(en2), .sample(smp),
        .new_frame(nf2), .bclk(bclk2), .lrclk(lr2), .sdata(sd2), .busy(busy2)
    );

    i2s_sample_tx #(.CLK_DIV(3), .SAMPLE_BITS(16)) u_dut3 (
        .clk(clk), .reset(rst_n), .enable(en3), .sample(smp),
        .new_frame(nf3), .bclk(bclk3), .lrclk(lr3), .sdata(sd3), .busy(busy3)
    );

    i2s_sample_tx #(.CLK_DIV(4), .SAMPLE_BITS(16)) u_dut4 (
        .clk(clk), .reset(rst_n), .enable(en4), .sample(smp),
        .new_frame(nf4), .bclk(bclk4), .lrclk(lr4), .sdata(sd4), .busy(busy4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic nf_of(input int which);
        case (which)
            3:       return nf3;
            4:       return nf4;
            default: return nf2;
        endcase
    endfunction

    // Returns the number of cycles until new_frame is seen, capped at budget.
    task automatic wait_nf(input int which, input int budget, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (nf_of(which) == 1'b0 && n < budget);
    endtask

    // Receiver model for the CLK_DIV=2 instance: samples sdata on bclk rising edges.
    initial begin : mon2
        int          bitcnt;
        logic [31:0] fw;
        logic        pb;
        logic [15:0] e;
        bitcnt = 0;
        fw     = '0;
        pb     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bitcnt = 0;
                pb     = 1'b0;
            end else begin
                if (nf2) begin
                    bitcnt = 0;
                    nf_count2++;
                end
                if (bclk2 && !pb) begin
                    check("lrclk_slot", 32'(lr2), (bitcnt < 16) ? 32'd1 : 32'd0);
                    fw = {fw[30:0], sd2};
                    bitcnt++;
                    if (bitcnt == 32) begin
                        bitcnt = 0;
                        if (exp_q.size() == 0) begin
                            check("sb_unexpected_frame", 32'(exp_q.size()), 32'd1);
                        end else begin
                            e = exp_q.pop_front();
                            check("frame_left", 32'(fw[31:16]), 32'(e));
                            check("frame_right", 32'(fw[15:0]), 32'(e));
                            frames_done++;
                        end
                    end
                end
                pb = bclk2;
            end
        end
    end

    // Phase-length and data-edge monitor for the CLK_DIV=3 instance.
    initial begin : mon3
        logic pb, psd, pbusy;
        int   run;
        bit   started;
        pb = 1'b0; psd = 1'b0; pbusy = 1'b0; run = 0; started = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !busy3) begin
                started = 1'b0;
            end
            if (rst_n) begin
                if (bclk3 != pb) begin
                    if (started) begin
                        check("bclk3_phase", 32'(run), 32'd3);
                        runs3++;
                    end
                    started = busy3;
                    run     = 1;
                end else begin
                    run++;
                end
                if (busy3 && pbusy && sd3 != psd) begin
                    check("sdata3_on_fall", 32'({pb, bclk3}), 32'b10);
                end
            end
            pb = bclk3; psd = sd3; pbusy = busy3;
        end
    end

    initial begin
        int n;
        int snap;
        rst_n = 1'b1;
        en2 = 1'b0; en3 = 1'b0; en4 = 1'b0;
        smp = '0;
        #2 rst_n = 1'b0;
        tick(3);
        check("reset_dut2", 32'({nf2, bclk2, lr2, sd2, busy2}), 32'd0);
        check("reset_dut3", 32'({nf3, bclk3, lr3, sd3, busy3}), 32'd0);
        check("reset_dut4", 32'({nf4, bclk4, lr4, sd4, busy4}), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // single frame contents and pacing over five frames, then drain from slot 5
        smp = 16'hA5C3;
        repeat (5) exp_q.push_back(16'hA5C3);
        en2 = 1'b1;
        wait_nf(2, 10, n);
        check("first_nf_latency", 32'(n), 32'd1);
        check("frame0_outputs", 32'({bclk2, lr2, sd2, busy2}), 32'b0111);
        tick(1);
        check("nf_single_cycle", 32'(nf2), 32'd0);
        for (int i = 0; i < 4; i++) begin
            wait_nf(2, 300, n);
            check("pace_div2", 32'(n), (i == 0) ? 32'd127 : 32'd128);
        end
        tick(20);
        en2 = 1'b0;
        tick(1);
        check("drain_busy", 32'(busy2), 32'd1);
        tick(106);
        check("drain_last_cycle_busy", 32'(busy2), 32'd1);
        tick(1);
        check("drain_idle_outputs", 32'({nf2, bclk2, lr2, sd2, busy2}), 32'd0);
        snap = nf_count2;
        tick(200);
        check("no_nf_after_drain", 32'(nf_count2), 32'(snap));
        check("nf_pulses_div2", 32'(nf_count2), 32'd5);
        check("frames_after_pacing", 32'(frames_done), 32'd5);

        // drain at slot 5, re-raise at slot 20: frame continues without a gap
        smp = 16'h1234;
        exp_q.push_back(16'h1234);
        en2 = 1'b1;
        wait_nf(2, 10, n);
        check("restart_latency", 32'(n), 32'd1);
        tick(20);
        en2 = 1'b0;
        tick(60);
        check("drain_mid_busy", 32'(busy2), 32'd1);
        en2 = 1'b1;
        smp = 16'h5678;
        exp_q.push_back(16'h5678);
        wait_nf(2, 100, n);
        check("reraise_no_gap", 32'(n), 32'd48);
        en2 = 1'b0;
        tick(128);
        check("drain2_idle", 32'(busy2), 32'd0);

        // capture timing around the last cycle of slot 31
        smp = 16'h0001;
        exp_q.push_back(16'h0001);
        en2 = 1'b1;
        wait_nf(2, 10, n);
        tick(127);
        smp = 16'h8000;
        exp_q.push_back(16'h8000);
        tick(1);
        check("frame2_start", 32'(nf2), 32'd1);
        smp = 16'h0001;
        exp_q.push_back(16'h0001);
        tick(128);
        check("frame3_start", 32'(nf2), 32'd1);
        smp = 16'h8000;
        en2 = 1'b0;
        tick(128);
        check("capture_idle", 32'(busy2), 32'd0);

        // asynchronous reset in the middle of a frame
        smp = 16'hFFFF;
        en2 = 1'b1;
        wait_nf(2, 10, n);
        tick(40);
        check("prereset_active", 32'({busy2, lr2, sd2}), 32'b111);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({nf2, bclk2, lr2, sd2, busy2}), 32'd0);
        en2 = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // pacing with CLK_DIV=4
        en4 = 1'b1;
        wait_nf(4, 10, n);
        check("div4_latency", 32'(n), 32'd1);
        for (int i = 0; i < 4; i++) begin
            wait_nf(4, 600, n);
            check("pace_div4", 32'(n), 32'd256);
        end
        en4 = 1'b0;
        tick(300);
        check("div4_idle", 32'(busy4), 32'd0);

        // bit clock with CLK_DIV=3; enable drops on the final cycle of the second frame
        en3 = 1'b1;
        wait_nf(3, 10, n);
        check("div3_latency", 32'(n), 32'd1);
        tick(383);
        check("div3_last_cycle", 32'({busy3, bclk3, lr3}), 32'b110);
        en3 = 1'b0;
        tick(1);
        check("div3_stop_on_last", 32'({nf3, busy3, bclk3}), 32'd0);
        check("div3_phase_runs", (runs3 >= 100) ? 32'd1 : 32'd0, 32'd1);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("frames_total", 32'(frames_done), 32'd10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
